fir_stream_scheduler: RTL and testbench

Sequencer that wraps one FIR filter with a streaming interface. Upstream samples arrive over valid/ready into a small FIFO. The scheduler issues them one at a time to the filter's `input_valid`/`ready_for_input` handshake and captures each result into a held output register with downstream valid/ready. It also enforces a response timeout and counts completed results.

---
 rtl/fir_sched_pkg.sv | 14 +
 rtl/fir_sched_fifo.sv | 46 ++++
 rtl/fir_stream_scheduler.sv | 105 ++++++++++
 tb/tb_fir_stream_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR stream scheduler.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } fir_sched_state_t;

  function automatic int fir_out_width(input int width, input int lenght);
    return $clog2(lenght) + 2 * width;
  endfunction

endpackage

// File: rtl/fir_sched_fifo.sv
// Small synchronous FIFO feeding the scheduler; DEPTH must be a power of two.
module fir_sched_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_stream_scheduler.sv
// Streams samples through a single FIR filter, one outstanding at a time,
// with a held result register, response timeout and result counter.
module fir_stream_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int LENGHT    = 100,
  parameter  int DEPTH     = 4,
  parameter  int TIMEOUT   = 256,
  localparam int OUT_WIDTH = fir_out_width(WIDTH, LENGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     fir_input,
  output logic                 fir_input_valid,
  input  logic                 fir_ready_for_input,
  input  logic [OUT_WIDTH-1:0] fir_output,
  input  logic                 fir_output_valid,
  output logic                 timeout_err,
  output logic [15:0]          result_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  fir_sched_state_t state;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] fifo_head, issue_data;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty, fifo_unused;
  logic             push, issue;

  assign s_ready     = (fifo_count < CW'(DEPTH));
  assign push        = s_valid && s_ready;
  assign fifo_unused = fifo_full;

  // An empty FIFO with a sample arriving forwards it straight to the filter,
  // so an idle scheduler issues one cycle after upstream acceptance.
  assign issue      = (state == IDLE) && fir_ready_for_input && (!fifo_empty || push);
  assign issue_data = fifo_empty ? s_data : fifo_head;

  fir_sched_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .wdata (s_data),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      timer           <= '0;
      fir_input       <= '0;
      fir_input_valid <= 1'b0;
      m_data          <= '0;
      m_valid         <= 1'b0;
      timeout_err     <= 1'b0;
      result_count    <= '0;
    end else begin
      fir_input_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            fir_input       <= issue_data;
            fir_input_valid <= 1'b1;
            timer           <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          timer <= timer + 1'b1;
          // A result arriving on the last allowed cycle still counts.
          if (fir_output_valid) begin
            m_data       <= fir_output;
            m_valid      <= 1'b1;
            result_count <= result_count + 16'd1;
            state        <= HOLD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        HOLD: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_scheduler.sv
// Self-checking bench: reset, table of single transactions, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_fir_stream_scheduler;

  localparam int W  = 16;
  localparam int OW = 39;
  localparam int D  = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [OW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  fir_input;
  logic          fir_input_valid;
  logic          fir_ready = 1'b1;
  logic [OW-1:0] fir_output = '0;
  logic          fir_output_valid = 1'b0;
  logic          timeout_err;
  logic [15:0]   result_count;

  int checks = 0;
  int failures = 0;

  // filter model state: fm_delay = cycles from issue to response, 0 = never
  int           fm_delay = 5;
  int           fm_cnt = 0;
  logic [W-1:0] fm_x = '0;

  // reference model for random traffic
  logic [W-1:0]  acc_q[$];
  logic [OW-1:0] exp_q[$];
  int            occ = 0;
  int            nres = 0;
  bit            exp_err = 0;

  fir_stream_scheduler #(.WIDTH(W), .LENGHT(100), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .s_data              (s_data),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .m_data              (m_data),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .fir_input           (fir_input),
    .fir_input_valid     (fir_input_valid),
    .fir_ready_for_input (fir_ready),
    .fir_output          (fir_output),
    .fir_output_valid    (fir_output_valid),
    .timeout_err         (timeout_err),
    .result_count        (result_count)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] resp(input logic [W-1:0] x);
    return OW'(x) << 5;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // advance one cycle; sample #1 after the edge and run the filter model
  task automatic tick();
    @(posedge clk);
    #1;
    fir_output_valid = 1'b0;
    if (fm_cnt > 0) begin
      fm_cnt--;
      if (fm_cnt == 0) begin
        fir_output_valid = 1'b1;
        fir_output       = resp(fm_x);
      end
    end
    if (fir_input_valid) begin
      fm_cnt = fm_delay;
      fm_x   = fir_input;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    tick();
    tick();
    reset            = 1'b0;
    fm_cnt           = 0;
    fir_output_valid = 1'b0;
  endtask

  task automatic wait_m(input string nm);
    int n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_mvalid_wait"}, m_valid, 1);
  endtask

  task automatic rand_cycle(input bit drain);
    bit pushed, held;
    logic [OW-1:0] prev;
    logic [W-1:0] x;
    if (drain) begin
      s_valid = 1'b0; m_ready = 1'b1; fir_ready = 1'b1;
    end else begin
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = W'($urandom);
      m_ready   = ($urandom_range(0, 9) < 7);
      fir_ready = ($urandom_range(0, 9) < 8);
    end
    fm_delay = $urandom_range(1, TO);
    pushed = s_valid && s_ready;
    chk("rnd_sready", s_ready, (occ < D));
    if (pushed) acc_q.push_back(s_data);
    if (m_valid && m_ready) begin
      chk("rnd_result_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rnd_mdata", m_data, exp_q.pop_front());
    end
    held = m_valid && !m_ready;
    prev = m_data;
    tick();
    if (pushed) occ++;
    if (fir_input_valid) begin
      occ--;
      chk("rnd_issue_expected", (acc_q.size() > 0), 1);
      if (acc_q.size() > 0) begin
        x = acc_q.pop_front();
        chk("rnd_fir_input", fir_input, x);
        if (fm_delay < TO) begin
          exp_q.push_back(resp(x));
          nres++;
        end else exp_err = 1;
      end
    end
    if (held) begin
      chk("rnd_hold_valid", m_valid, 1);
      chk("rnd_hold_data", m_data, prev);
    end
  endtask

  typedef struct {
    logic [W-1:0]  sample;
    int            delay;
    logic [OW-1:0] exp_data;
    int            exp_lat;
    bit            exp_to;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int   n, exp_cnt;
    bit   bad;
    logic [OW-1:0] held_data;

    tbl[0] = '{16'h0005, 5, 39'h00_0000_00A0, 6, 0};
    tbl[1] = '{16'hFFFF, 1, 39'h00_001F_FFE0, 2, 0};
    tbl[2] = '{16'h8000, 7, 39'h00_0010_0000, 8, 0};
    tbl[3] = '{16'h1234, 3, 39'h00_0002_4680, 4, 0};
    tbl[4] = '{16'h00AA, 0, 39'h0,            8, 1};

    // reset with s_valid asserted
    reset = 1'b1; s_valid = 1'b1; s_data = 16'h0077;
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_fir_input", fir_input, 0);
    chk("rst_fir_input_valid", fir_input_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_result_count", result_count, 0);
    chk("rst_s_ready", s_ready, 1);
    reset = 1'b0; s_valid = 1'b0;
    tick();
    chk("rst_release_s_ready", s_ready, 1);
    chk("rst_nothing_written", fir_input_valid, 0);
    tick();
    chk("rst_nothing_written2", fir_input_valid, 0);

    // single transactions from the table
    exp_cnt = 0;
    m_ready = 1'b1;
    foreach (tbl[k]) begin
      s_data = tbl[k].sample; s_valid = 1'b1; fm_delay = tbl[k].delay;
      tick();
      s_valid = 1'b0;
      chk("tbl_issue_valid", fir_input_valid, 1);
      chk("tbl_issue_data", fir_input, tbl[k].sample);
      tick();
      n = 1;
      chk("tbl_issue_one_cycle", fir_input_valid, 0);
      while (!(m_valid || timeout_err) && n < 40) begin
        tick();
        n++;
      end
      chk("tbl_latency", n, tbl[k].exp_lat);
      if (tbl[k].exp_to) begin
        chk("tbl_to_err", timeout_err, 1);
        chk("tbl_to_no_mvalid", m_valid, 0);
        chk("tbl_to_count", result_count, exp_cnt);
      end else begin
        chk("tbl_m_data", m_data, tbl[k].exp_data);
        tick();
        exp_cnt++;
        chk("tbl_m_valid_clear", m_valid, 0);
        chk("tbl_count", result_count, exp_cnt);
      end
    end

    // filter not ready, FIFO fill, ordering under backpressure
    do_reset();
    fir_ready = 1'b0; m_ready = 1'b0; fm_delay = 3;
    for (int j = 0; j < D; j++) begin
      s_data = W'(j + 1); s_valid = 1'b1;
      chk("fill_s_ready", s_ready, 1);
      tick();
    end
    s_valid = 1'b0;
    chk("full_s_ready_low", s_ready, 0);
    bad = 0;
    repeat (16) begin
      tick();
      if (fir_input_valid) bad = 1;
    end
    chk("notready_no_issue", bad, 0);
    fir_ready = 1'b1;
    tick();
    chk("ready_issue_valid", fir_input_valid, 1);
    chk("ready_issue_data", fir_input, 1);
    chk("ready_s_ready_back", s_ready, 1);
    wait_m("hold");
    held_data = m_data;
    chk("hold_first_data", m_data, 39'h20);
    bad = 0;
    repeat (10) begin
      tick();
      if (!m_valid || m_data !== held_data || fir_input_valid) bad = 1;
    end
    chk("hold_stable", bad, 0);
    m_ready = 1'b1;
    for (int j = 0; j < D; j++) begin
      wait_m("order");
      chk("order_data", m_data, resp(W'(j + 1)));
      tick();
    end
    chk("order_count", result_count, 4);

    // timeout followed by issue of the next queued sample
    do_reset();
    fm_delay = 0; m_ready = 1'b1;
    s_data = 16'h0011; s_valid = 1'b1;
    tick();
    chk("to_issue_a", fir_input, 16'h0011);
    s_data = 16'h0022;
    tick();
    s_valid = 1'b0;
    repeat (6) tick();
    chk("to_err_before", timeout_err, 0);
    fm_delay = 2;
    tick();
    chk("to_err_at_issue_plus_timeout", timeout_err, 1);
    chk("to_no_mvalid", m_valid, 0);
    tick();
    chk("to_next_issue_valid", fir_input_valid, 1);
    chk("to_next_issue_data", fir_input, 16'h0022);
    wait_m("to_b");
    chk("to_b_data", m_data, 39'h440);
    tick();
    chk("to_count", result_count, 1);
    chk("to_err_sticky", timeout_err, 1);

    // reset while busy with two samples queued
    do_reset();
    fm_delay = 0; m_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      s_data = W'(16'h31 + j); s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; fm_cnt = 0;
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_count", result_count, 0);
    fir_output = 39'h123; fir_output_valid = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (m_valid || fir_input_valid) bad = 1;
    end
    chk("midrst_late_ignored", bad, 0);
    chk("midrst_count_after", result_count, 0);
    chk("midrst_err", timeout_err, 0);

    // randomized traffic against the reference model
    do_reset();
    acc_q.delete(); exp_q.delete();
    occ = 0; nres = 0; exp_err = 0;
    repeat (3000) rand_cycle(1'b0);
    repeat (200) rand_cycle(1'b1);
    chk("rnd_exp_drained", exp_q.size(), 0);
    chk("rnd_acc_drained", acc_q.size(), 0);
    chk("rnd_result_count", result_count, 16'(nres));
    chk("rnd_timeout_err", timeout_err, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
